// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter with a bounded lock that shares one data memory
// between two masters. It returns registered read data one cycle after a granted read.
`default_nettype none

module data_mem_arbiter #(
   parameter int WIDTH    = 32,
   parameter int MAX_LOCK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic             lock0,
   input  logic             lock1,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] mem_address,
   output logic             mem_write_read,
   output logic [WIDTH-1:0] mem_write_data,
   input  logic [WIDTH-1:0] mem_read_data
);

   localparam int                CNT_W      = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] C_MAX_LOCK = CNT_W'(MAX_LOCK);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic               r_rr_ptr, w_rr_ptr_nxt;
   logic [CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
   logic               w_hold0, w_hold1;
   logic               w_gnt0, w_gnt1;
   logic               r_rvalid0, r_rvalid1;
   logic [WIDTH-1:0]   r_rdata0, r_rdata1;

   always_comb begin
      w_hold0        = (r_state == S_OWN0) && req0 && lock0 && (r_lock_cnt < C_MAX_LOCK);
      w_hold1        = (r_state == S_OWN1) && req1 && lock1 && (r_lock_cnt < C_MAX_LOCK);
      w_gnt0         = 1'b0;
      w_gnt1         = 1'b0;
      w_state_nxt    = S_IDLE;
      w_lock_cnt_nxt = '0;
      w_rr_ptr_nxt   = r_rr_ptr;

      // Grants are suppressed while reset is high so nothing reaches the memory.
      if (!reset) begin
         if (w_hold0) begin
            w_gnt0 = 1'b1;
         end else if (w_hold1) begin
            w_gnt1 = 1'b1;
         end else if (req0 && req1) begin
            w_gnt0 = ~r_rr_ptr;
            w_gnt1 = r_rr_ptr;
         end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
         end
      end

      if (w_gnt0 && !w_hold0) w_rr_ptr_nxt = 1'b1;
      if (w_gnt1 && !w_hold1) w_rr_ptr_nxt = 1'b0;

      if (w_gnt0 && lock0) begin
         w_state_nxt    = S_OWN0;
         w_lock_cnt_nxt = w_hold0 ? r_lock_cnt + CNT_W'(1) : CNT_W'(1);
      end else if (w_gnt1 && lock1) begin
         w_state_nxt    = S_OWN1;
         w_lock_cnt_nxt = w_hold1 ? r_lock_cnt + CNT_W'(1) : CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 1'b0;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
      end else begin
         r_rvalid0 <= w_gnt0 && !we0;
         r_rvalid1 <= w_gnt1 && !we1;
         if (w_gnt0 && !we0) r_rdata0 <= mem_read_data;
         if (w_gnt1 && !we1) r_rdata1 <= mem_read_data;
      end
   end

   assign gnt0           = w_gnt0;
   assign gnt1           = w_gnt1;
   assign rvalid0        = r_rvalid0;
   assign rvalid1        = r_rvalid1;
   assign rdata0         = r_rdata0;
   assign rdata1         = r_rdata1;
   assign mem_address    = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
   assign mem_write_data = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
   assign mem_write_read = (w_gnt0 && we0) || (w_gnt1 && we1);

endmodule

`default_nettype wire
